// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte-stream handshake bundle feeding the program loader
//
// in_valid : source has a byte on in_byte
// in_ready : loader accepts the byte on this posedge
// in_byte  : stream byte
// master = byte source, slave = loader
interface prog_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;

    modport master (output in_valid, output in_byte, input in_ready);
    modport slave  (input in_valid, input in_byte, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream program loader writing 16-bit words into RAM
//
// clk, rst_n           : clock, synchronous active-low reset
// in_s                 : byte stream (in_valid/in_ready/in_byte)
// ram_addr/ram_wdata   : registered write address/data, stable during the write cycle
// ram_cs/ram_we/ram_oe : RAM strobes; cs/we high for exactly one cycle per word, oe tied 0
// busy                 : loader owns the RAM port
// cpu_start/start_pc   : one-cycle start pulse and entry PC after a good checksum
// done/err             : sticky success / failure flags
module prog_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prog_loader_if.slave          in_s,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic                  busy,
    output logic                  cpu_start,
    output logic [ADDR_WIDTH-1:0] start_pc,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [3:0] {
        S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO,
        S_DATA_HI, S_DATA_LO, S_WRITE, S_CSUM,
        S_DONE, S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            addr_hi_q;
    logic [7:0]            cnt_hi_q;
    logic [7:0]            data_hi_q;
    logic [7:0]            xor_q;
    logic [15:0]           remaining_q;
    logic [ADDR_WIDTH-1:0] load_addr_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic                  accept;
    logic [15:0]           addr_full;
    logic [15:0]           cnt_full;

    assign addr_full = {addr_hi_q, in_s.in_byte};
    assign cnt_full  = {cnt_hi_q, in_s.in_byte};
    assign accept    = in_s.in_valid && in_s.in_ready;

    always_comb begin
        state_d     = state_q;
        in_s.in_ready = 1'b0;
        ram_cs      = 1'b0;
        ram_we      = 1'b0;
        ram_oe      = 1'b0;
        busy        = 1'b1;
        case (state_q)
            S_ADDR_HI: begin
                in_s.in_ready = rst_n;
                if (accept) state_d = S_ADDR_LO;
            end
            S_ADDR_LO: begin
                in_s.in_ready = rst_n;
                if (accept) state_d = in_s.in_byte[0] ? S_ERR : S_CNT_HI;
            end
            S_CNT_HI: begin
                in_s.in_ready = rst_n;
                if (accept) state_d = S_CNT_LO;
            end
            S_CNT_LO: begin
                in_s.in_ready = rst_n;
                if (accept) state_d = (cnt_full == 16'd0) ? S_CSUM : S_DATA_HI;
            end
            S_DATA_HI: begin
                in_s.in_ready = rst_n;
                if (accept) state_d = S_DATA_LO;
            end
            S_DATA_LO: begin
                in_s.in_ready = rst_n;
                if (accept) state_d = S_WRITE;
            end
            S_WRITE: begin
                ram_cs  = 1'b1;
                ram_we  = 1'b1;
                state_d = (remaining_q == 16'd1) ? S_CSUM : S_DATA_HI;
            end
            S_CSUM: begin
                in_s.in_ready = rst_n;
                if (accept) state_d = (in_s.in_byte == xor_q) ? S_DONE : S_ERR;
            end
            S_DONE:  busy = 1'b0;
            S_ERR:   busy = 1'b0;
            default: state_d = S_ADDR_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_ADDR_HI;
            addr_hi_q   <= '0;
            cnt_hi_q    <= '0;
            data_hi_q   <= '0;
            xor_q       <= '0;
            remaining_q <= '0;
            load_addr_q <= '0;
            wr_ptr_q    <= '0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            cpu_start   <= 1'b0;
            start_pc    <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpu_start <= 1'b0;

            // Checksum restarts at the frame head; the CSUM byte itself is excluded.
            if (state_q == S_ADDR_HI)
                xor_q <= accept ? in_s.in_byte : 8'h00;
            else if (accept && state_q != S_CSUM)
                xor_q <= xor_q ^ in_s.in_byte;

            if (accept) begin
                case (state_q)
                    S_ADDR_HI: addr_hi_q <= in_s.in_byte;
                    S_ADDR_LO: begin
                        load_addr_q <= addr_full[ADDR_WIDTH-1:0];
                        wr_ptr_q    <= addr_full[ADDR_WIDTH-1:0];
                    end
                    S_CNT_HI:  cnt_hi_q    <= in_s.in_byte;
                    S_CNT_LO:  remaining_q <= cnt_full;
                    S_DATA_HI: data_hi_q   <= in_s.in_byte;
                    S_DATA_LO: begin
                        ram_addr  <= wr_ptr_q;
                        ram_wdata <= {data_hi_q, in_s.in_byte};
                    end
                    default: ;
                endcase
            end

            if (state_q == S_WRITE) begin
                wr_ptr_q    <= wr_ptr_q + ADDR_WIDTH'(2);
                remaining_q <= remaining_q - 16'd1;
            end

            if (state_d == S_DONE && state_q != S_DONE) begin
                cpu_start <= 1'b1;
                done      <= 1'b1;
                start_pc  <= load_addr_q;
            end

            if (state_d == S_ERR && state_q != S_ERR)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed scoreboard bench for prog_loader
module tb_prog_loader;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_wdata;
    logic          ram_cs, ram_we, ram_oe, busy, cpu_start, done, err;
    logic [AW-1:0] start_pc;

    prog_loader_if sif ();

    prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_s      (sif.slave),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .busy      (busy),
        .cpu_start (cpu_start),
        .start_pc  (start_pc),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } wr_t;

    int            checks = 0;
    int            errors = 0;
    wr_t           sb[$];
    logic [15:0]   mem [0:2047];
    logic [15:0]   words [0:17];
    int            n_writes = 0;
    int            n_starts = 0;
    logic [AW-1:0] pc_at_start = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write/start monitor: pops the scoreboard on every RAM write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_we) begin
                wr_t e;
                n_writes++;
                check("wr_cs", {31'd0, ram_cs}, 32'd1);
                check("wr_oe", {31'd0, ram_oe}, 32'd0);
                check("wr_in_ready", {31'd0, sif.in_ready}, 32'd0);
                checks++;
                assert (sb.size() > 0)
                else begin
                    errors++;
                    $error("FAIL wr_unexpected observed addr=%0h data=%0h expected no write", ram_addr, ram_wdata);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("wr_addr", {20'd0, ram_addr}, {20'd0, e.a});
                    check("wr_data", {16'd0, ram_wdata}, {16'd0, e.d});
                end
                mem[ram_addr[AW-1:1]] = ram_wdata;
            end
            if (cpu_start) begin
                n_starts++;
                pc_at_start = start_pc;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_byte = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, sif.in_ready}, 32'd0);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_ram_cs", {31'd0, ram_cs}, 32'd0);
        check("rst_ram_oe", {31'd0, ram_oe}, 32'd0);
        check("rst_ram_addr", {20'd0, ram_addr}, 32'd0);
        check("rst_ram_wdata", {16'd0, ram_wdata}, 32'd0);
        check("rst_cpu_start", {31'd0, cpu_start}, 32'd0);
        check("rst_start_pc", {20'd0, start_pc}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        sb.delete();
        n_writes = 0;
        n_starts = 0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, sif.in_ready}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps && $urandom_range(0, 2) == 0) begin
            sif.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        sif.in_valid = 1'b1;
        sif.in_byte  = b;
        t = 0;
        while (!sif.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("byte_ready", {31'd0, sif.in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        sif.in_valid = 1'b0;
    endtask

    // Sends words[0..n-1] at addr; stop_after >= 0 abandons the frame after that many words.
    task automatic send_frame(input logic [15:0] addr, input int n, input bit bad_csum,
                              input bit gaps, input int stop_after);
        logic [7:0]    x;
        logic [15:0]   cnt;
        logic [AW-1:0] a;
        wr_t           e;
        cnt = 16'(n);
        x = addr[15:8] ^ addr[7:0] ^ cnt[15:8] ^ cnt[7:0];
        send_byte(addr[15:8], gaps);
        send_byte(addr[7:0], gaps);
        send_byte(cnt[15:8], gaps);
        send_byte(cnt[7:0], gaps);
        for (int i = 0; i < n; i++) begin
            if (i == stop_after) return;
            a = addr[AW-1:0] + AW'(2 * i);
            e.a = a;
            e.d = words[i];
            sb.push_back(e);
            x = x ^ words[i][15:8] ^ words[i][7:0];
            send_byte(words[i][15:8], gaps);
            send_byte(words[i][7:0], gaps);
        end
        send_byte(bad_csum ? (x ^ 8'h01) : x, gaps);
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!(done || err) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("end_reached", {31'd0, (done || err)}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        sif.in_valid = 1'b0;
        sif.in_byte  = 8'h00;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;

        // Good two-word frame at 0x100
        do_reset();
        words[0] = 16'h111C;
        words[1] = 16'h711A;
        send_frame(16'h0100, 2, 1'b0, 1'b0, -1);
        wait_end();
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_err", {31'd0, err}, 32'd0);
        check("t1_starts", n_starts, 32'd1);
        check("t1_pc_at_start", {20'd0, pc_at_start}, 32'h100);
        check("t1_start_pc", {20'd0, start_pc}, 32'h100);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_in_ready", {31'd0, sif.in_ready}, 32'd0);
        check("t1_writes", n_writes, 32'd2);
        check("t1_sb_empty", sb.size(), 32'd0);

        // Same frame, bad checksum
        do_reset();
        send_frame(16'h0100, 2, 1'b1, 1'b0, -1);
        wait_end();
        check("t2_done", {31'd0, done}, 32'd0);
        check("t2_err", {31'd0, err}, 32'd1);
        check("t2_starts", n_starts, 32'd0);
        check("t2_writes", n_writes, 32'd2);
        check("t2_busy", {31'd0, busy}, 32'd0);

        // Odd load address
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        check("t3_err", {31'd0, err}, 32'd1);
        check("t3_in_ready", {31'd0, sif.in_ready}, 32'd0);
        repeat (5) @(negedge clk);
        check("t3_writes", n_writes, 32'd0);
        check("t3_starts", n_starts, 32'd0);
        check("t3_done", {31'd0, done}, 32'd0);

        // Empty program at 0x200
        do_reset();
        send_frame(16'h0200, 0, 1'b0, 1'b0, -1);
        wait_end();
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_starts", n_starts, 32'd1);
        check("t4_pc_at_start", {20'd0, pc_at_start}, 32'h200);
        check("t4_writes", n_writes, 32'd0);

        // Address wrap with random valid gaps
        do_reset();
        words[0] = 16'hAABB;
        words[1] = 16'hCCDD;
        send_frame(16'h0FFE, 2, 1'b0, 1'b1, -1);
        wait_end();
        check("t5_done", {31'd0, done}, 32'd1);
        check("t5_writes", n_writes, 32'd2);
        check("t5_sb_empty", sb.size(), 32'd0);
        check("t5_mem_ffe", {16'd0, mem[11'h7FF]}, 32'hAABB);
        check("t5_mem_000", {16'd0, mem[11'h000]}, 32'hCCDD);
        check("t5_start_pc", {20'd0, start_pc}, 32'hFFE);

        // 18-word program, reset after word 5, then clean resend
        words[0]  = 16'h111C; words[1]  = 16'h711A; words[2]  = 16'h2345; words[3]  = 16'h6789;
        words[4]  = 16'h9ABC; words[5]  = 16'hDEF0; words[6]  = 16'h0F1E; words[7]  = 16'h2D3C;
        words[8]  = 16'h4B5A; words[9]  = 16'h6978; words[10] = 16'h8796; words[11] = 16'hA5B4;
        words[12] = 16'hC3D2; words[13] = 16'hE1F0; words[14] = 16'h1357; words[15] = 16'h2468;
        words[16] = 16'h8000; words[17] = 16'hFFFF;
        do_reset();
        send_frame(16'h0100, 18, 1'b0, 1'b0, 5);
        repeat (3) @(negedge clk);
        check("t6_partial_writes", n_writes, 32'd5);
        check("t6_partial_sb_empty", sb.size(), 32'd0);
        do_reset();
        repeat (5) @(negedge clk);
        check("t6_no_start_before_resend", n_starts, 32'd0);
        check("t6_no_done_before_resend", {31'd0, done}, 32'd0);
        send_frame(16'h0100, 18, 1'b0, 1'b0, -1);
        wait_end();
        check("t6_done", {31'd0, done}, 32'd1);
        check("t6_starts", n_starts, 32'd1);
        check("t6_pc_at_start", {20'd0, pc_at_start}, 32'h100);
        check("t6_writes", n_writes, 32'd18);
        for (int i = 0; i < 18; i++)
            check($sformatf("t6_mem_%0h", 16'h100 + 2 * i), {16'd0, mem[11'h080 + 11'(i)]}, {16'd0, words[i]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
